// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run controller: run-state encodings,
// control register bit positions and the SoC address map it lives in.
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } run_state_t;

    localparam int CTRL_HALT = 0;
    localparam int CTRL_SRST = 1;

    localparam logic [31:0] BOOT_ROM_BASE = 32'h0000_0000;
    localparam logic [31:0] SRAM_BASE     = 32'h1000_0000;
    localparam logic [31:0] RUN_CTRL_ADDR = 32'h2000_0000;

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_btn.sv
// Board button conditioner: two-flop synchronizer, debounce counter that
// accepts a new level after DEBOUNCE stable cycles, and a one-cycle pulse
// on each rising edge of the accepted level. rst_s is active-low.
module btn_debounce
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DEBOUNCE = 65535
) (
    input  logic clkout,
    input  logic rst_s,
    input  logic btn,
    output logic pulse
);

    localparam int CW = cnt_width(DEBOUNCE);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    // Bring the raw button into the clkout domain.
    always_ff @(posedge clkout or negedge rst_s) begin
        if (!rst_s) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Accept the synced level only once it has differed from the current one for DEBOUNCE cycles.
    always_ff @(posedge clkout or negedge rst_s) begin
        if (!rst_s) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE - 1)) begin
            cnt   <= '0;
            level <= sync2;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Registered one-cycle pulse on each rising edge of the accepted level.
    always_ff @(posedge clkout or negedge rst_s) begin
        if (!rst_s) begin
            level_q <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            level_q <= level;
            pulse   <= level & ~level_q;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: synchronizes the board reset, stretches the CPU reset,
// and gates the CPU clock enable for free-run, halt and single-step modes.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int RESET_HOLD = 16,
    parameter int DEBOUNCE   = 65535,
    parameter int START_RUN  = 1
) (
    input  logic        clkout,
    input  logic        ext_reset,
    input  logic        btn_step,
    input  logic        btn_mode,
    input  logic        ctrl_wen,
    input  logic [1:0]  ctrl_wdata,
    output logic        cpu_resetn,
    output logic        cpu_clk_en,
    output logic        running,
    output logic [15:0] step_count
);

    localparam int HW = cnt_width(RESET_HOLD);
    localparam run_state_t START_STATE = (START_RUN != 0) ? S_RUN : S_HALT;
    localparam logic START_IS_RUN = (START_RUN != 0);

    logic          rst_meta;
    logic          rst_s;
    logic          step_p;
    logic          mode_p;
    logic          soft_rst;
    logic          wr_halt;
    logic          wr_run;
    logic [HW-1:0] hold_cnt;
    run_state_t    state;

    // Board reset asserts immediately and releases two clkout edges later.
    always_ff @(posedge clkout or negedge ext_reset) begin
        if (!ext_reset) begin
            rst_meta <= 1'b0;
            rst_s    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_s    <= rst_meta;
        end
    end

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_step_btn (
        .clkout (clkout),
        .rst_s  (rst_s),
        .btn    (btn_step),
        .pulse  (step_p)
    );

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_mode_btn (
        .clkout (clkout),
        .rst_s  (rst_s),
        .btn    (btn_mode),
        .pulse  (mode_p)
    );

    assign soft_rst = ctrl_wen & ctrl_wdata[CTRL_SRST];
    assign wr_halt  = ctrl_wen & ctrl_wdata[CTRL_HALT];
    assign wr_run   = ctrl_wen & ~ctrl_wdata[CTRL_HALT];

    // Run-state machine; a bus write outranks the mode button, which outranks a step.
    always_ff @(posedge clkout or negedge rst_s) begin
        if (!rst_s) begin
            state      <= S_HOLD;
            hold_cnt   <= '0;
            cpu_resetn <= 1'b0;
            cpu_clk_en <= 1'b0;
            running    <= 1'b0;
            step_count <= 16'd0;
        end else if (soft_rst) begin
            state      <= S_HOLD;
            hold_cnt   <= '0;
            cpu_resetn <= 1'b0;
            cpu_clk_en <= 1'b1;
            running    <= 1'b0;
            step_count <= 16'd0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (hold_cnt == HW'(RESET_HOLD - 1)) begin
                        hold_cnt   <= '0;
                        state      <= START_STATE;
                        cpu_resetn <= 1'b1;
                        cpu_clk_en <= START_IS_RUN;
                        running    <= START_IS_RUN;
                    end else begin
                        hold_cnt   <= hold_cnt + HW'(1);
                        cpu_resetn <= 1'b0;
                        cpu_clk_en <= 1'b1;
                        running    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (wr_halt || (!ctrl_wen && mode_p)) begin
                        state      <= S_HALT;
                        cpu_clk_en <= 1'b0;
                        running    <= 1'b0;
                    end else begin
                        cpu_clk_en <= 1'b1;
                        running    <= 1'b1;
                    end
                end
                S_HALT: begin
                    if (wr_run || (!ctrl_wen && mode_p)) begin
                        state      <= S_RUN;
                        cpu_clk_en <= 1'b1;
                        running    <= 1'b1;
                    end else begin
                        cpu_clk_en <= step_p;
                        running    <= 1'b0;
                        if (step_p) begin
                            step_count <= step_count + 16'd1;
                        end
                    end
                end
                default: begin
                    state      <= S_HOLD;
                    hold_cnt   <= '0;
                    cpu_resetn <= 1'b0;
                    cpu_clk_en <= 1'b1;
                    running    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: a behavioural model predicts the
// outputs after every clock edge and a negedge monitor compares them.
module tb_cpu_run_ctrl;

    localparam int D  = 4;
    localparam int RH = 16;
    localparam int SR = 1;

    localparam int M_HOLD = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        clkout     = 1'b0;
    logic        ext_reset  = 1'b1;
    logic        btn_step   = 1'b0;
    logic        btn_mode   = 1'b0;
    logic        ctrl_wen   = 1'b0;
    logic [1:0]  ctrl_wdata = 2'b00;
    logic        cpu_resetn;
    logic        cpu_clk_en;
    logic        running;
    logic [15:0] step_count;

    typedef struct packed {
        logic        rn;
        logic        en;
        logic        run;
        logic [15:0] cnt;
    } exp_t;

    exp_t expq[$];
    exp_t e_now;

    int tests = 0;
    int fails = 0;
    int cycle = 0;

    int rel;
    bit samp [2][D+2];
    bit lvl  [2];
    bit rise1[2];
    bit rise2[2];
    int m_state;
    int m_hold;

    cpu_run_ctrl #(
        .RESET_HOLD (RH),
        .DEBOUNCE   (D),
        .START_RUN  (SR)
    ) dut (
        .clkout     (clkout),
        .ext_reset  (ext_reset),
        .btn_step   (btn_step),
        .btn_mode   (btn_mode),
        .ctrl_wen   (ctrl_wen),
        .ctrl_wdata (ctrl_wdata),
        .cpu_resetn (cpu_resetn),
        .cpu_clk_en (cpu_clk_en),
        .running    (running),
        .step_count (step_count)
    );

    always #5 clkout = ~clkout;

    function void reset_model();
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < D + 2; k++) samp[b][k] = 1'b0;
            lvl[b]   = 1'b0;
            rise1[b] = 1'b0;
            rise2[b] = 1'b0;
        end
        m_state = M_HOLD;
        m_hold  = 0;
        e_now   = '0;
    endfunction

    // A button level is accepted once the samples taken 2..D+1 edges ago all disagree with it;
    // the pulse reaches the controller two edges after acceptance.
    function void button_edge(input int b, input bit raw, output bit p);
        bit stable;
        bit nl;
        p = rise2[b];
        stable = 1'b1;
        for (int k = 2; k <= D + 1; k++)
            if (samp[b][k] == lvl[b]) stable = 1'b0;
        nl = stable ? !lvl[b] : lvl[b];
        rise2[b] = rise1[b];
        rise1[b] = !lvl[b] && nl;
        lvl[b]   = nl;
        for (int k = D + 1; k >= 2; k--) samp[b][k] = samp[b][k-1];
        samp[b][1] = raw;
    endfunction

    function void model_edge();
        bit sp;
        bit mp;
        bit go;
        if (!ext_reset) begin
            rel = 0;
            reset_model();
            return;
        end
        if (rel < 2) begin
            rel++;
            reset_model();
            return;
        end
        button_edge(0, btn_step, sp);
        button_edge(1, btn_mode, mp);
        if (ctrl_wen && ctrl_wdata[1]) begin
            m_state   = M_HOLD;
            m_hold    = 0;
            e_now.rn  = 1'b0;
            e_now.en  = 1'b1;
            e_now.run = 1'b0;
            e_now.cnt = 16'd0;
        end else begin
            case (m_state)
                M_HOLD: begin
                    m_hold++;
                    if (m_hold == RH) begin
                        m_state   = (SR != 0) ? M_RUN : M_HALT;
                        e_now.rn  = 1'b1;
                        e_now.en  = (SR != 0);
                        e_now.run = (SR != 0);
                    end else begin
                        e_now.rn  = 1'b0;
                        e_now.en  = 1'b1;
                        e_now.run = 1'b0;
                    end
                end
                M_RUN: begin
                    go = ctrl_wen ? ctrl_wdata[0] : mp;
                    if (go) begin
                        m_state   = M_HALT;
                        e_now.en  = 1'b0;
                        e_now.run = 1'b0;
                    end else begin
                        e_now.en  = 1'b1;
                        e_now.run = 1'b1;
                    end
                end
                default: begin
                    go = ctrl_wen ? !ctrl_wdata[0] : mp;
                    if (go) begin
                        m_state   = M_RUN;
                        e_now.en  = 1'b1;
                        e_now.run = 1'b1;
                    end else begin
                        e_now.run = 1'b0;
                        e_now.en  = sp;
                        if (sp) e_now.cnt = e_now.cnt + 16'd1;
                    end
                end
            endcase
        end
    endfunction

    task applyStimulus(input bit rn, input bit bs, input bit bm, input bit wen, input bit [1:0] wd);
        ext_reset  = rn;
        btn_step   = bs;
        btn_mode   = bm;
        ctrl_wen   = wen;
        ctrl_wdata = wd;
        @(posedge clkout);
        cycle++;
        model_edge();
        expq.push_back(e_now);
        #1;
    endtask

    task checkOutput(input exp_t e);
        tests++;
        if (cpu_resetn !== e.rn || cpu_clk_en !== e.en || running !== e.run || step_count !== e.cnt) begin
            fails++;
            if (fails <= 20)
                $display("[TB] FAIL outputs cycle %0d: got resetn=%b clk_en=%b running=%b step_count=%0d, expected resetn=%b clk_en=%b running=%b step_count=%0d",
                         cycle, cpu_resetn, cpu_clk_en, running, step_count, e.rn, e.en, e.run, e.cnt);
        end
    endtask

    task idle(input int n);
        repeat (n) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    task write_ctrl(input bit [1:0] wd);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, wd);
    endtask

    task press_step(input int n);
        repeat (n) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        idle(10);
    endtask

    task press_mode(input int n);
        repeat (n) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
        idle(10);
    endtask

    // Monitor: every output sample is checked against the oldest prediction.
    always @(negedge clkout) begin
        if (expq.size() > 0) checkOutput(expq.pop_front());
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit       seen;
        bit       bs;
        bit       bm;
        bit       wen;
        bit [1:0] wd;

        rel = 0;
        reset_model();
        #2;

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        idle(25);

        write_ctrl(2'b01);
        idle(3);
        repeat (3) press_step(10);

        for (int i = 0; i < 20; i++)
            applyStimulus(1'b1, ((i / 2) % 2) == 0, 1'b0, 1'b0, 2'b00);
        press_step(10);

        write_ctrl(2'b00);
        idle(3);
        press_mode(10);
        press_mode(10);
        press_step(10);

        write_ctrl(2'b01);
        repeat (5) press_step(10);
        write_ctrl(2'b10);
        idle(25);

        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
            seen = rise1[1];
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("[TB] FAIL collision_setup: got no mode pulse, required one within 20 cycles");
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 2'b11);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
        idle(25);

        bs = 1'b0;
        bm = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) bs = !bs;
            if ($urandom_range(0, 7) == 0) bm = !bm;
            wen = ($urandom_range(0, 19) == 0);
            wd  = 2'($urandom_range(0, 3));
            if (wd[1] && $urandom_range(0, 2) != 0) wd[1] = 1'b0;
            applyStimulus(1'b1, bs, bm, wen, wd);
        end

        idle(30);
        write_ctrl(2'b00);
        idle(3);
        @(negedge clkout);
        #1;
        ext_reset = 1'b0;
        #1;
        tests++;
        if (cpu_resetn !== 1'b0 || cpu_clk_en !== 1'b0 || running !== 1'b0 || step_count !== 16'd0) begin
            fails++;
            $display("[TB] FAIL async_reset: got resetn=%b clk_en=%b running=%b step_count=%0d, required all zero",
                     cpu_resetn, cpu_clk_en, running, step_count);
        end
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        idle(25);

        @(negedge clkout);
        #1;
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: got %0d unchecked predictions, required 0", expq.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Sequences CPU reset and execution in the SoC top: synchronizes the board reset, stretches CPU reset, and gates the CPU clock enable.
- Supports free-run, halt and single-step modes, driven by debounced board buttons and a small memory-mapped control register on the data bus.
- Replaces the ad-hoc reset/debounce state machine in the top level; cpu_clk_en is consumed by the CPU clock-gating mux.

Parameters:
- RESET_HOLD, 16, clkout cycles cpu_resetn is held low after any reset source (min 1).
- DEBOUNCE, 65535, cycles a button input must be stable before the new level is accepted (min 1).
- START_RUN, 1, mode after reset: 1 = run, 0 = halt.

Ports:
- clkout  in  1  system clock, 27 MHz
- ext_reset  in  1  asynchronous, active-low board reset
- btn_step  in  1  raw asynchronous step button, active-high
- btn_mode  in  1  raw asynchronous run/halt toggle button, active-high
- ctrl_wen  in  1  bus write strobe to the control register, one cycle
- ctrl_wdata  in  2  bit0 = halt request (1 halt, 0 run); bit1 = soft reset request
- cpu_resetn  out  1  CPU reset, active-low
- cpu_clk_en  out  1  CPU clock enable
- running  out  1  high in S_RUN
- step_count  out  16  single steps issued since the last reset; wraps

Behaviour:
- Reset: ext_reset is asserted asynchronously and deasserted through a 2-flop synchronizer (rst_s). All other logic resets asynchronously on rst_s.
- Reset values: cpu_resetn=0, cpu_clk_en=0, running=0, step_count=0, state=S_HOLD, hold counter=0, debouncer outputs=0.
- Buttons: each button passes through a 2-flop synchronizer, then a debounce counter.
  - The counter resets whenever the synced input differs from the accepted level.
  - When the counter reaches DEBOUNCE-1, the accepted level updates on the next edge.
  - A rising edge of the accepted level produces a one-cycle pulse (step_p, mode_p).
  - Latency from a clean input edge to the pulse is DEBOUNCE+3 cycles.
- S_HOLD:
  - cpu_resetn=0, cpu_clk_en=1, so the CPU sees its reset clocked.
  - Count RESET_HOLD cycles, then enter S_RUN if START_RUN=1, else S_HALT.
  - cpu_resetn rises on the same edge as the state change.
- S_RUN:
  - cpu_clk_en=1, running=1.
  - Go to S_HALT on mode_p, or on ctrl_wen with wdata[0]=1.
- S_HALT:
  - cpu_clk_en=0 except during step pulses.
  - On step_p: cpu_clk_en=1 for exactly one cycle (the cycle after step_p); step_count increments on the same edge.
  - Go to S_RUN on mode_p, or on ctrl_wen with wdata[0]=0.
- Soft reset: ctrl_wen with wdata[1]=1 in any state →
  - next cycle: cpu_resetn=0, state=S_HOLD, hold counter cleared, step_count cleared;
  - mode afterwards follows START_RUN.
- Priority when events coincide: soft reset > ctrl_wen halt/run > mode_p > step_p.
  - step_p is ignored outside S_HALT.
  - step_p in the same cycle as a mode_p leaving S_HALT is dropped.
- Other boundary rules:
  - ctrl_wen with wdata[0] requesting the mode already active: no-op.
  - A button pressed during S_HOLD is debounced normally, but its pulse is discarded.
  - ext_reset asserted mid-operation: all outputs return to reset values immediately (asynchronously).
  - step_count wraps 0xFFFF→0x0000 with no flag.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package: state encodings S_HOLD=2'd0, S_RUN=2'd1, S_HALT=2'd2, and control register bit indices (CTRL_HALT=0, CTRL_SRST=1), alongside existing SoC address constants.
- One sub-module: btn_debounce (synchronizer + debounce counter + rising-edge pulse, parameter DEBOUNCE), instantiated twice.
- The 2-flop reset synchronizer stays inline.

Test Plan:
- Power-up: DEBOUNCE=4, RESET_HOLD=16, START_RUN=1; release ext_reset → cpu_resetn=0 for 2+16 cycles, then 1 with running=1 and cpu_clk_en=1 continuously.
- Halt/step: ctrl_wen with wdata=2'b01 → running=0 and cpu_clk_en=0 next cycle. Then press btn_step for 10 cycles, three times → exactly three single-cycle cpu_clk_en pulses, each 7 cycles after the press edge; step_count=3.
- Bounce: btn_step toggles every 2 cycles for 20 cycles, then holds high → exactly one pulse; step_count increments by 1.
- Mode button in run: START_RUN=1, press btn_mode → S_HALT; press again → S_RUN; step presses while running leave step_count unchanged.
- Soft reset: from halt with step_count=5, ctrl_wen with wdata=2'b10 → cpu_resetn=0 for 16 cycles, step_count=0, then running=1.
- Collision and async reset: ctrl_wen with wdata=2'b11 in the same cycle as mode_p → soft reset wins. Assert ext_reset mid-S_RUN → cpu_resetn=0 and cpu_clk_en=0 without waiting for a clock edge.
